// File: rtl/wallace_cpa_stage.sv
// Final carry-propagate adder of the Wallace-tree multiplier: folds the sum/carry
// vector pair into a binary product over a two-stage pipeline split at W/2.
module wallace_cpa_stage #(
  parameter int W = 16,
  localparam int H = W / 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_sum,
  input  logic [W-1:0] in_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_cout
);

  function automatic logic [H:0] add_half(input logic [H-1:0] a,
                                          input logic [H-1:0] b,
                                          input logic         cin);
    return {1'b0, a} + {1'b0, b} + {{H{1'b0}}, cin};
  endfunction

  logic         s1_valid_q;
  logic [H-1:0] s1_lo_q;
  logic         s1_c_q;
  logic [H-1:0] s1_sum_hi_q;
  logic [H-1:0] s1_car_hi_q;

  logic         s2_valid_q;
  logic [W-1:0] s2_prod_q;
  logic         s2_cout_q;

  logic         s1_adv;
  logic         s2_adv;
  logic [H:0]   s1_lo_d;
  logic [H:0]   s2_hi_d;

  always_comb begin
    s2_adv  = !s2_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    s1_lo_d = add_half(in_sum[H-1:0], in_carry[H-1:0], 1'b0);
    s2_hi_d = add_half(s1_sum_hi_q, s1_car_hi_q, s1_c_q);
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_prod  = s2_prod_q;
  assign out_cout  = s2_cout_q;

  // Stage 1: low-half add, upper halves carried forward untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_sum_hi_q <= '0;
      s1_car_hi_q <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_lo_q     <= s1_lo_d[H-1:0];
        s1_c_q      <= s1_lo_d[H];
        s1_sum_hi_q <= in_sum[W-1:H];
        s1_car_hi_q <= in_carry[W-1:H];
      end
    end
  end

  // Stage 2: upper-half add absorbing the low-half carry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_cout_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_q <= {s2_hi_d[H-1:0], s1_lo_q};
        s2_cout_q <= s2_hi_d[H];
      end
    end
  end

endmodule

// File: tb/tb_wallace_cpa_stage.sv
// Directed and randomized checks of the wallace_cpa_stage two-stage adder pipeline.
module tb_wallace_cpa_stage;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic         out_cout;

  int checks = 0;
  int errors = 0;

  wallace_cpa_stage #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_carry (in_carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod),
    .out_cout (out_cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_carry = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_prod !== 16'h0000) begin errors++; $display("FAIL reset_out_prod got %h want 0000", out_prod); end
    checks++;
    if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sum = 16'h00FF; in_carry = 16'h0001;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 out_valid got %b want 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++;
    if (out_prod !== 16'h0100 || out_cout !== 1'b0)
      begin errors++; $display("FAIL basic_prod got %b_%h want 0_0100", out_cout, out_prod); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] vs [3]  = '{16'hFFFF, 16'h8000, 16'h1234};
    logic [W-1:0] vc [3]  = '{16'h0001, 16'h8000, 16'h4321};
    logic [W-1:0] ep [3]  = '{16'h0000, 16'h0000, 16'h5555};
    logic         ec [3]  = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sum = vs[i]; in_carry = vc[i];
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_prod !== ep[i] || out_cout !== ec[i])
        begin errors++; $display("FAIL wrap_%0d got v=%b %b_%h want v=1 %b_%h", i, out_valid, out_cout, out_prod, ec[i], ep[i]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q [$];
    logic [W:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_sum   = 16'h0F0F * i[W-1:0] + 16'h00F1;
        in_carry = 16'h0101 * i[W-1:0] + 16'h000F;
        exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready_%0d got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_cout, out_prod} !== e)
          begin errors++; $display("FAIL stream_%0d got v=%b %h want v=1 %h", i - 1, out_valid, {out_cout, out_prod}, e); end
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 16'h0001; in_carry = 16'h0001;
    step();
    in_sum = 16'h0002; in_carry = 16'h0002;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b want 1", in_ready); end
    step();
    in_sum = 16'h0003; in_carry = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_%0d in_ready got %b want 0", i, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_prod !== 16'h0002)
        begin errors++; $display("FAIL bp_hold_%0d got v=%b %h want v=1 0002", i, out_valid, out_prod); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_passthru in_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_prod !== 16'h0004)
      begin errors++; $display("FAIL bp_drain1 got v=%b %h want v=1 0004", out_valid, out_prod); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_prod !== 16'h0006)
      begin errors++; $display("FAIL bp_drain2 got v=%b %h want v=1 0006", out_valid, out_prod); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 16'h0005; in_carry = 16'h0005;
    step();
    in_sum = 16'h0007; in_carry = 16'h0007;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_prod !== 16'h0000 || out_cout !== 1'b0)
      begin errors++; $display("FAIL midrst_clear got v=%b %b_%h want v=0 0_0000", out_valid, out_cout, out_prod); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet_%0d out_valid got %b want 0", i, out_valid); end
    end
    in_valid = 1'b1; in_sum = 16'h0009; in_carry = 16'h0009;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_lat out_valid got %b want 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_prod !== 16'h0012)
      begin errors++; $display("FAIL midrst_new got v=%b %h want v=1 0012", out_valid, out_prod); end
    step();
  endtask

  task automatic test_random();
    logic [W:0]   exp_q [$];
    logic [W:0]   e;
    logic         held;
    logic [W:0]   held_val;
    int           pushed;
    int           cyc;
    held = 1'b0; held_val = '0; pushed = 0; cyc = 0;
    while (pushed < 10000 && cyc < 40000) begin
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {out_cout, out_prod} !== held_val)
          begin errors++; $display("FAIL rand_stall cyc %0d got v=%b %h want v=1 %h", cyc, out_valid, {out_cout, out_prod}, held_val); end
      end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_sum    = W'($urandom);
      in_carry  = ($urandom_range(7) == 0) ? ~in_sum + W'($urandom_range(1)) : W'($urandom);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc %0d got %h want none", cyc, {out_cout, out_prod});
        end else begin
          e = exp_q.pop_front();
          if ({out_cout, out_prod} !== e)
            begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", cyc, {out_cout, out_prod}, e); end
        end
      end
      held     = out_valid && !out_ready;
      held_val = {out_cout, out_prod};
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
        pushed++;
      end
      step();
      cyc++;
    end
    checks++;
    if (pushed != 10000) begin errors++; $display("FAIL rand_budget pushed %0d want 10000", pushed); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_drain_spurious got %h want none", {out_cout, out_prod});
        end else begin
          e = exp_q.pop_front();
          if ({out_cout, out_prod} !== e)
            begin errors++; $display("FAIL rand_drain got %h want %h", {out_cout, out_prod}, e); end
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover count %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wallace_cpa_stage.md
Name: wallace_cpa_stage

Overview:
- Final carry-propagate adder stage of the Wallace-tree multiplier.
- Consumes the redundant sum/carry vector pair left by the FA/HA reduction tree and produces the binary product.
- Two-stage pipeline, split at W/2, with valid/ready handshake on both sides.
- Throughput is one result per clock.

Parameters:
- W, 16: width of the sum/carry vectors and of the product (2×multiplier operand width). Must be even and ≥4.
- H, W/2: low-half width. Derived; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream presents a vector pair.
- in_ready  output  1  stage can accept a pair this cycle.
- in_sum  input  W  sum vector from reduction tree.
- in_carry  input  W  carry vector from reduction tree, already bit-aligned (weight 2^i at bit i).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result this cycle.
- out_prod  output  W  (in_sum + in_carry) mod 2^W.
- out_cout  output  1  bit W of the full sum. Nonzero only for malformed tree output; treated as an error flag by downstream.

Behaviour:
- Transfer rules:
  - An input transfer occurs on an edge where in_valid && in_ready.
  - An output transfer occurs on an edge where out_valid && out_ready.
- Stage 1 (S1) registers:
  - s1_valid
  - s1_lo: H-bit sum of in_sum[H-1:0] + in_carry[H-1:0]
  - s1_c: carry out of the low half
  - s1_sum_hi, s1_car_hi: the upper H bits of each operand
- Stage 2 (S2) registers:
  - s2_valid, which drives out_valid
  - out_prod: {upper-half sum, s1_lo}, where upper-half sum = s1_sum_hi + s1_car_hi + s1_c
  - out_cout: carry out of the upper half
- Advance conditions:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational; no combinational path from in_valid to in_ready)
- S1 update:
  - On s1_adv, S1 loads the input and s1_valid <= in_valid.
  - Otherwise S1 holds.
- S2 update:
  - On s2_adv, S2 loads from S1 and s2_valid <= s1_valid.
  - Otherwise S2 holds.
- Data registers load only when the corresponding valid source is 1. Bubbles do not disturb held data.
- Latency: 2 cycles. A pair accepted at edge k is visible on out_prod after edge k+1 and transfers at the earliest on edge k+2.
- Capacity: 2 entries.
  - With out_ready held low, exactly two pairs are accepted, then in_ready = 0.
  - in_ready returns to 1 in the same cycle out_ready returns to 1 (pass-through ready).
- Stall stability: while out_valid && !out_ready, out_prod and out_cout are held stable.
- Simultaneous events: when S1 and S2 are both full and out_ready = 1, an output transfer and an input transfer in the same cycle are both legal. No bubble is inserted.
- Arithmetic:
  - Purely unsigned modular addition.
  - Half-carry ripples exactly once across the S1→S2 boundary.
  - No saturation.
- Reset: when rst_n = 0 at an edge:
  - s1_valid, s2_valid, out_prod, out_cout <= 0
  - All other data registers <= 0
  - in_ready reads 1 in the first cycle after reset
- Reset mid-operation: all in-flight results are discarded. No partial result appears on out_valid afterward.
- X-safety: out_prod and out_cout are 0 before the first valid result.

Test Plan:
1. Basic add, W=16: in_sum=0x00FF, in_carry=0x0001, out_ready=1 -> two edges later out_valid=1, out_prod=0x0100, out_cout=0. Exercises the cross-half carry.
2. Wrap: in_sum=0xFFFF, in_carry=0x0001 -> out_prod=0x0000, out_cout=1. Then in_sum=0x8000, in_carry=0x8000 -> out_prod=0x0000, out_cout=1. Then 0x1234 + 0x4321 -> 0x5555, out_cout=0.
3. Streaming: 8 back-to-back pairs with in_valid=1 and out_ready=1 every cycle -> 8 correct results on 8 consecutive cycles starting 2 cycles after the first; in_ready stays 1 throughout.
4. Backpressure: out_ready=0 while offering 3 pairs (0x0001+0x0001, 0x0002+0x0002, 0x0003+0x0003) -> only 2 accepted and in_ready=0. out_prod holds 0x0002 stable. Raising out_ready drains 0x0002, 0x0004, 0x0006 in order with no loss or duplication.
5. Reset mid-op: with 2 entries in flight, pull rst_n=0 for one edge -> out_valid=0, out_prod=0, in_ready=1 next cycle. Nothing emitted until new input plus 2 cycles.
6. Random: 10,000 random pairs with random in_valid/out_ready -> scoreboard matches (in_sum+in_carry) as a 17-bit value {out_cout,out_prod}, order preserved, no stall-time output changes.
